// File: rtl/score_display_ctrl_if.sv
// Bus between the game logic and the score/message display controller.
// The game side drives scores and messages; the controller returns the digit bus and status.
interface score_display_ctrl_if;
   logic [13:0] score_in;
   logic        score_load;
   logic [15:0] msg_in;
   logic        msg_load;
   logic [15:0] digits;
   logic        conv_busy;
   logic        msg_active;

   modport master (
      output score_in, score_load, msg_in, msg_load,
      input  digits, conv_busy, msg_active
   );

   modport slave (
      input  score_in, score_load, msg_in, msg_load,
      output digits, conv_busy, msg_active
   );
endinterface

// File: rtl/score_display_ctrl.sv
// Score-to-BCD conversion (sequential double dabble) and arbitration of the
// 4-digit display between the score and timed overlay messages.
module score_display_ctrl #(
   parameter int HOLD_CYCLES = 50000000,
   parameter int HOLD_W      = 26
) (
   input  logic                 clk,
   input  logic                 rst,
   score_display_ctrl_if.slave  bus
);

   localparam int          CONV_STEPS = 14;
   localparam logic [13:0] SCORE_MAX  = 14'd9999;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } conv_state_e;

   // Asynchronous assertion, synchronised release so every register leaves reset on the same edge.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   conv_state_e state_q, state_d;
   logic [29:0] shift_q, shift_d;
   logic [3:0]  iter_q, iter_d;
   logic        busy_q, busy_d;
   logic [15:0] score_bcd_q, score_bcd_d;
   logic [13:0] pend_q, pend_d;
   logic        pend_flag_q, pend_flag_d;

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              active_q, active_d;
   logic [15:0]       msg_q, msg_d;

   logic [13:0] score_sat;
   logic [15:0] bcd_adj;
   logic [29:0] shift_next;

   assign score_sat = (bus.score_in > SCORE_MAX) ? SCORE_MAX : bus.score_in;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dabble
         logic [3:0] nib;
         assign nib = shift_q[14 + 4*gi +: 4];
         assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   endgenerate

   assign shift_next = {bcd_adj[14:0], shift_q[13:0], 1'b0};

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         iter_q      <= '0;
         busy_q      <= 1'b0;
         score_bcd_q <= '0;
         pend_q      <= '0;
         pend_flag_q <= 1'b0;
         hold_q      <= '0;
         active_q    <= 1'b0;
         msg_q       <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         iter_q      <= iter_d;
         busy_q      <= busy_d;
         score_bcd_q <= score_bcd_d;
         pend_q      <= pend_d;
         pend_flag_q <= pend_flag_d;
         hold_q      <= hold_d;
         active_q    <= active_d;
         msg_q       <= msg_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      iter_d      = iter_q;
      busy_d      = busy_q;
      score_bcd_d = score_bcd_q;
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;

      case (state_q)
         IDLE: begin
            // A fresh load in IDLE supersedes any pending value: it is the newest score.
            if (bus.score_load) begin
               shift_d     = {16'h0000, score_sat};
               iter_d      = '0;
               busy_d      = 1'b1;
               pend_flag_d = 1'b0;
               state_d     = CONV;
            end else if (pend_flag_q) begin
               shift_d     = {16'h0000, pend_q};
               iter_d      = '0;
               busy_d      = 1'b1;
               pend_flag_d = 1'b0;
               state_d     = CONV;
            end
         end
         CONV: begin
            shift_d = shift_next;
            if (iter_q == 4'(CONV_STEPS - 1)) begin
               score_bcd_d = shift_next[29:14];
               busy_d      = 1'b0;
               state_d     = IDLE;
            end else begin
               iter_d = iter_q + 4'd1;
            end
            if (bus.score_load) begin
               pend_d      = score_sat;
               pend_flag_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      hold_d   = hold_q;
      active_d = active_q;
      msg_d    = msg_q;
      if (bus.msg_load) begin
         msg_d    = bus.msg_in;
         hold_d   = HOLD_W'(HOLD_CYCLES - 1);
         active_d = 1'b1;
      end else if (active_q) begin
         if (hold_q == '0) begin
            active_d = 1'b0;
         end else begin
            hold_d = hold_q - 1'b1;
         end
      end
   end

   assign bus.digits     = active_q ? msg_q : score_bcd_q;
   assign bus.conv_busy  = busy_q;
   assign bus.msg_active = active_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: table of score conversions plus
// hand-written sequences for pending loads, message hold/retrigger and reset.
`timescale 1ns/1ps
module tb_score_display_ctrl;

   localparam int HOLD = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   score_display_ctrl_if bus ();

   score_display_ctrl #(.HOLD_CYCLES(HOLD), .HOLD_W(26)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [13:0] score;
      logic [15:0] bcd;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input logic [15:0] d, input logic b, input logic a);
      chk({nm, " digits"}, bus.digits, d);
      chk({nm, " busy"}, {15'd0, bus.conv_busy}, {15'd0, b});
      chk({nm, " active"}, {15'd0, bus.msg_active}, {15'd0, a});
   endtask

   logic [15:0] shown;

   initial begin
      vecs[0] = '{14'd1234,  16'h1234};
      vecs[1] = '{14'd12000, 16'h9999};
      vecs[2] = '{14'd0,     16'h0000};
      vecs[3] = '{14'd9,     16'h0009};
      vecs[4] = '{14'd9999,  16'h9999};
      vecs[5] = '{14'd10000, 16'h9999};
      vecs[6] = '{14'd5678,  16'h5678};
      vecs[7] = '{14'd16383, 16'h9999};
      vecs[8] = '{14'd100,   16'h0100};

      bus.score_in = '0; bus.score_load = 1'b0;
      bus.msg_in = '0;   bus.msg_load = 1'b0;

      // Reset and idle
      repeat (3) tick();
      chk_all("reset", 16'h0000, 1'b0, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk_all("idle", 16'h0000, 1'b0, 1'b0);
      end
      shown = 16'h0000;

      // Table of conversions
      for (int v = 0; v < 9; v++) begin
         $display("vector %0d: score=%0d expect=%h", v, vecs[v].score, vecs[v].bcd);
         bus.score_in = vecs[v].score; bus.score_load = 1'b1;
         tick();
         bus.score_load = 1'b0;
         chk_all("conv start", shown, 1'b1, 1'b0);
         for (int k = 1; k < 14; k++) begin
            tick();
            chk_all("conv mid", shown, 1'b1, 1'b0);
         end
         tick();
         chk_all("conv done", vecs[v].bcd, 1'b0, 1'b0);
         shown = vecs[v].bcd;
         tick();
      end

      // Pending loads: 777 is overwritten by 805 while 42 converts
      $display("pending loads 42/777/805");
      bus.score_in = 14'd42; bus.score_load = 1'b1;
      for (int e = 0; e <= 29; e++) begin
         tick();
         bus.score_load = 1'b0;
         if (e == 2) begin bus.score_in = 14'd777; bus.score_load = 1'b1; end
         if (e == 4) begin bus.score_in = 14'd805; bus.score_load = 1'b1; end
         if (e < 14)       chk_all("pend first", shown, 1'b1, 1'b0);
         else if (e == 14) chk_all("pend first done", 16'h0042, 1'b0, 1'b0);
         else if (e < 29)  chk_all("pend second", 16'h0042, 1'b1, 1'b0);
         else              chk_all("pend second done", 16'h0805, 1'b0, 1'b0);
      end
      tick();
      chk_all("pend empty", 16'h0805, 1'b0, 1'b0);

      bus.score_in = 14'd100; bus.score_load = 1'b1;
      tick();
      bus.score_load = 1'b0;
      repeat (15) tick();
      chk_all("restore 100", 16'h0100, 1'b0, 1'b0);

      // Single message hold
      $display("message A5C3 hold");
      bus.msg_in = 16'hA5C3; bus.msg_load = 1'b1;
      for (int e = 0; e <= 8; e++) begin
         tick();
         bus.msg_load = 1'b0;
         if (e < 8) chk_all("msg hold", 16'hA5C3, 1'b0, 1'b1);
         else       chk_all("msg expire", 16'h0100, 1'b0, 1'b0);
      end

      // Retrigger before expiry
      $display("message retrigger at edge 7");
      bus.msg_in = 16'hA5C3; bus.msg_load = 1'b1;
      for (int e = 0; e <= 15; e++) begin
         tick();
         bus.msg_load = 1'b0;
         if (e == 6) begin bus.msg_in = 16'h00FF; bus.msg_load = 1'b1; end
         if (e < 7)       chk_all("retrig first", 16'hA5C3, 1'b0, 1'b1);
         else if (e < 15) chk_all("retrig second", 16'h00FF, 1'b0, 1'b1);
         else             chk_all("retrig expire", 16'h0100, 1'b0, 1'b0);
      end

      // Load coincident with expiry
      $display("message load at expiry edge");
      bus.msg_in = 16'hC0DE; bus.msg_load = 1'b1;
      for (int e = 0; e <= 16; e++) begin
         tick();
         bus.msg_load = 1'b0;
         if (e == 7) begin bus.msg_in = 16'hFACE; bus.msg_load = 1'b1; end
         if (e < 8)       chk_all("expiry first", 16'hC0DE, 1'b0, 1'b1);
         else if (e < 16) chk_all("expiry reload", 16'hFACE, 1'b0, 1'b1);
         else             chk_all("expiry end", 16'h0100, 1'b0, 1'b0);
      end

      // Conversion finishing under a message
      $display("conversion 2468 under message BEEF");
      bus.score_in = 14'd2468; bus.score_load = 1'b1;
      for (int e = 0; e <= 18; e++) begin
         tick();
         bus.score_load = 1'b0;
         bus.msg_load = 1'b0;
         if (e == 9) begin bus.msg_in = 16'hBEEF; bus.msg_load = 1'b1; end
         if (e < 10)      chk_all("under pre", 16'h0100, 1'b1, 1'b0);
         else if (e < 14) chk_all("under msg busy", 16'hBEEF, 1'b1, 1'b1);
         else if (e < 18) chk_all("under msg done", 16'hBEEF, 1'b0, 1'b1);
         else             chk_all("under reveal", 16'h2468, 1'b0, 1'b0);
      end

      // Reset mid-conversion and mid-hold
      $display("reset at cycle 5 of conversion");
      bus.score_in = 14'd4321; bus.score_load = 1'b1;
      bus.msg_in = 16'h1111;   bus.msg_load = 1'b1;
      tick();
      bus.score_load = 1'b0; bus.msg_load = 1'b0;
      bus.score_in = 14'd555; 
      repeat (4) tick();
      chk_all("pre reset", 16'h1111, 1'b1, 1'b1);
      bus.score_load = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk_all("async reset", 16'h0000, 1'b0, 1'b0);
      bus.score_load = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      for (int i = 0; i < 25; i++) begin
         tick();
         chk_all("post reset", 16'h0000, 1'b0, 1'b0);
      end

      $display("conversion 7 after reset");
      bus.score_in = 14'd7; bus.score_load = 1'b1;
      tick();
      bus.score_load = 1'b0;
      repeat (13) tick();
      chk_all("after reset mid", 16'h0000, 1'b1, 1'b0);
      tick();
      chk_all("after reset done", 16'h0007, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Drives the 16-bit hex digit bus of the 4-digit seven-segment display path (scan/decoder stage downstream).
- Converts a binary game score to 4-digit BCD with a sequential double-dabble engine.
- Arbitrates the single display between the persistent score and timed overlay messages (e.g. "PASS", combo codes); a message pre-empts the score for a fixed hold time.

Parameters:
- HOLD_CYCLES, 50000000, clk cycles a message stays on the display; legal range 1 to 2^HOLD_W-1.
- HOLD_W, 26, width of the hold counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- score_in  in  14  binary score; values >9999 saturate to 9999.
- score_load  in  1  one-cycle strobe, sample score_in.
- msg_in  in  16  four hex nibbles; [15:12] is the leftmost digit.
- msg_load  in  1  one-cycle strobe, sample msg_in and start the hold.
- digits  out  16  to display path; msg_reg while msg_active, else score_bcd. Combinational mux of registers only.
- conv_busy  out  1  BCD conversion in progress.
- msg_active  out  1  message currently owns the display.

Behaviour:
- Reset (rst=0, async):
  - score_bcd=0, msg_reg=0, digits=16'h0000.
  - conv_busy=0, msg_active=0, hold counter=0, pending flag clear, FSM=IDLE.
- Conversion FSM has two states, IDLE and CONV.
- IDLE, score_load=1 at edge E:
  - Load shift reg with min(score_in,9999), clear BCD accumulator, iteration count=0, go to CONV.
  - conv_busy rises at E.
- CONV, each edge (14 edges total, E+1..E+14):
  - For every BCD nibble >=5, add 3.
  - Then shift {bcd,bin} left by 1.
  - At the 14th edge (E+14), write the final BCD to score_bcd, clear conv_busy, return to IDLE.
  - conv_busy is high for exactly 14 cycles; load-to-score_bcd latency is 14 cycles.
- score_load while conv_busy=1:
  - Value goes to a single pending register; the latest value wins and sets the pending flag.
  - The running conversion is not disturbed.
  - At completion the FSM restarts CONV with the pending value on the next edge, clearing the flag. conv_busy drops for exactly one cycle between conversions.
- score_load in the same cycle a conversion completes: treated as pending; the restart follows.
- Message hold:
  - msg_load=1 at edge E: msg_reg<=msg_in, counter<=HOLD_CYCLES-1, msg_active<=1.
  - While active, the counter decrements each edge. At the edge where counter==0 and msg_load=0, msg_active<=0.
  - msg_active is high for exactly HOLD_CYCLES cycles per load.
- msg_load while active: retrigger. msg_reg is replaced, counter reloads, no gap in msg_active.
- msg_load coincident with expiry: the load wins and msg_active stays 1.
- Score conversions proceed independently during a message. The newest score_bcd appears on digits in the cycle after msg_active falls.
- msg_load and score_load in the same cycle: both are accepted independently.
- digits changes only at clock edges or on async reset; there are no combinational paths from inputs to digits.
- Reset asserted mid-conversion or mid-hold: everything returns to reset values immediately. The pending score is discarded.
- Deassertion of rst is synchronised internally (2-flop) so all FSMs leave reset on the same edge.

Test Plan:
- Reset then idle, 100 cycles -> digits=16'h0000, conv_busy=0, msg_active=0 throughout.
- score_in=1234, score_load at edge 0 -> conv_busy high for cycles 1..14; digits=16'h1234 from edge 14; intermediate values never appear on digits.
- score_in=12000 -> digits=16'h9999. score_in=0 -> 16'h0000. score_in=9 -> 16'h0009.
- Pending loads: load 42; at cycles 3 and 5 load 777, then 805 -> digits 16'h0042 at edge 14, conv_busy low one cycle, digits=16'h0805 at edge 29; 777 never shown.
- Message timing, HOLD_CYCLES=8, score shown 16'h0100: msg_in=16'hA5C3 load at edge 0 -> digits=16'hA5C3 for cycles 0..7, msg_active falls at edge 8, digits=16'h0100. Retrigger with 16'h00FF at edge 7 -> msg_active continuous until edge 15.
- Score conversion completing during a message -> digits holds the message until expiry, then shows the new BCD. Reset pulse at cycle 5 of a conversion -> all outputs return to 0 asynchronously; no stale conversion appears after release.
